spi_responder: RTL

SPI_RESPONDER -- requirements
Module: spi_responder

---
 rtl/spi_pkg.sv | 10 +
 rtl/sync_2ff.sv | 14 +
 rtl/spi_responder.sv | 94 +++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: SPI definitions shared by controller and responder (mode decode, FSM states).
package spi_pkg;
  typedef enum logic {IDLE, ACTIVE} spi_state_t;
  function automatic logic mode_cpol(input int mode);
    return mode == 2 || mode == 3;
  endfunction
  function automatic logic mode_cpha(input int mode);
    return mode == 1 || mode == 3;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI target (modes 0..3) oversampling the SPI pins on i_Clk, one-byte TX holding register.
module spi_responder
  import spi_pkg::*;
#(
  parameter int         SPI_MODE  = 0,
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);
  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);
  logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
  logic lead, trail, sample, shift, cs_fall, cs_rise, reload;
  logic [7:0] hold, tx_sr, rx_sr, next_tx;
  logic hold_full, done, armed;
  logic [1:0] settle;
  logic [2:0] bit_cnt;
  spi_state_t state;
  sync_2ff #(.RST_VAL(CPOL)) u_sync_clk  (.clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_Clk),  .q(sclk_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_CS_n), .q(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(i_Clk), .rst_n(i_Rst_L), .d(i_SPI_MOSI), .q(mosi_s));
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) {sclk_d, cs_d} <= {CPOL, 1'b1};
    else {sclk_d, cs_d} <= {sclk_s, cs_s};
  assign lead    = sclk_s != CPOL && sclk_d == CPOL;
  assign trail   = sclk_s == CPOL && sclk_d != CPOL;
  assign sample  = CPHA ? trail : lead;
  assign shift   = CPHA ? lead : trail;
  assign cs_fall = !cs_s && cs_d;
  assign cs_rise = cs_s && !cs_d;
  assign next_tx = hold_full ? hold : IDLE_FILL;
  assign reload  = state == IDLE ? cs_fall && armed : done && !cs_rise;
  assign o_TX_Ready = !hold_full;
  // armed only after a real CS-high is seen once the synchronizer holds pin data, so a CS already low at reset release is ignored
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state         <= IDLE;
      hold          <= '0;
      hold_full     <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      bit_cnt       <= 3'd7;
      done          <= 1'b0;
      armed         <= 1'b0;
      settle        <= '0;
      o_TX_Underrun <= 1'b0;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= '0;
      o_SPI_MISO    <= 1'b0;
      o_SPI_MISO_En <= 1'b0;
    end else begin
      settle        <= settle + {1'b0, settle != 2'd3};
      armed         <= armed | (settle == 2'd3 && cs_d);
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= reload && !hold_full;
      if (i_TX_DV) {hold, hold_full} <= {i_TX_Byte, 1'b1};
      else if (reload) hold_full <= 1'b0;
      if (reload) {tx_sr, bit_cnt} <= {next_tx, 3'd7};
      if (cs_rise) begin
        state         <= IDLE;
        bit_cnt       <= 3'd7;
        done          <= 1'b0;
        o_SPI_MISO    <= 1'b0;
        o_SPI_MISO_En <= 1'b0;
      end else if (state == IDLE) begin
        if (cs_fall && armed) begin
          state         <= ACTIVE;
          o_SPI_MISO    <= next_tx[7];
          o_SPI_MISO_En <= 1'b1;
        end
      end else begin
        if (done) {o_RX_DV, o_RX_Byte, done} <= {1'b1, rx_sr, 1'b0};
        if (sample) begin
          rx_sr   <= {rx_sr[6:0], mosi_s};
          bit_cnt <= bit_cnt - 3'd1;
          done    <= bit_cnt == 3'd0;
        end
        // indexing by the bit counter re-presents the MSb on the first shift edge after any reload
        if (shift) o_SPI_MISO <= tx_sr[bit_cnt];
      end
    end
endmodule
